branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Closes the loop on the 2-bit saturating-counter branch predictor. It records each prediction issued at fetch in an in-order queue and compares it against the real outcome when the branch resolves in execute. It drives the predictor's update strobe and real-outcome inputs, and on a mismatch it issues a one-cycle pipeline flush with the corrected PC. It sits between the fetch stage (push side), the execute stage (resolve side) and the predictor counter table (update side).

## Interface
Parameters:
- DEPTH, 4, in-flight branch queue entries; power of two, ≥2
- IDX_W, 6, predictor table index width
- PC_W, 32, program counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- pred_valid  in  1  fetch issued a predicted branch this cycle
- pred_idx  in  IDX_W  predictor table index of that branch
- pred_taken  in  1  prediction given (1 taken, 0 not taken)
- pred_ready  out  1  queue not full; the push happens only if pred_valid && pred_ready && !flush
- res_valid  in  1  execute resolved the oldest in-flight branch
- res_taken  in  1  real branch outcome
- res_pc_next  in  PC_W  architecturally correct next PC for that branch
- upd_en  out  1  one-cycle update strobe to the predictor
- upd_idx  out  IDX_W  predictor entry to update
- upd_taken  out  1  real outcome for the update
- flush  out  1  one-cycle mispredict flush
- redirect_pc  out  PC_W  fetch target, valid while flush=1

## Operation
- Queue entry holds {idx, taken}. Write pointer, read pointer and count are held in registers. Count width is $clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- Push: pred_valid && pred_ready && !flush writes an entry at wptr, then wptr+1.
- Resolve (res_valid with count>0): pop the head and register the update outputs for the next cycle: upd_en=1, upd_idx=head.idx, upd_taken=res_taken.
- Mispredict (res_taken != head.taken):
  - Next cycle: flush=1 and redirect_pc=res_pc_next.
  - The queue is cleared on the same edge as the pop (count=0, rptr=wptr). All younger entries are wrong-path.
  - A push in the same cycle is dropped.
- Correct prediction: no flush. A simultaneous push and pop leaves count unchanged.
- res_valid while count=0: ignored. No update, no flush, no state change.
- pred_ready = (count != DEPTH). It does not depend on res_valid, so there is no combinational path from execute to fetch. Pushing when full is blocked even if a pop happens in the same cycle.
- Pushes are also dropped during the flush cycle (fetch is still on the wrong path).
- Per-cycle state machine: NORMAL → FLUSH on mispredict; FLUSH → NORMAL after exactly one cycle. A resolve during FLUSH is processed normally, and a further mispredict keeps the machine in FLUSH for one more cycle.

## Timing
- Reset values: pred_ready=1, upd_en=0, upd_idx=0, upd_taken=0, flush=0, redirect_pc=0. Queue is empty and the state is NORMAL.
- Reset asserted mid-operation: the queue is discarded immediately, all outputs take their reset values asynchronously, and any pending update or flush is lost.
- Latency: res_valid at cycle N gives upd_en, and flush if mispredicted, at cycle N+1, each exactly one cycle wide.
- A pushed entry is resolvable from the cycle after the push.
- The predictor samples upd_en/upd_taken as its update_en/real_br_taken.

## Configuration
- BRU_STATS_EN defined:
  - Adds outputs stat_branches (32-bit, counts every valid resolve) and stat_mispred (32-bit, counts mispredicts).
  - Both reset to 0 and wrap at 2^32.
- BRU_STATS_EN undefined: those ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package bru_pkg:
  - bru_entry_t struct {idx, taken}
  - bru_state_e enum {BRU_NORMAL, BRU_FLUSH}
  - default parameter constants
- One sub-module, bru_queue: the circular buffer with push/pop/clear, count, full and empty. Mispredict detection and the output registers stay in branch_resolve_unit.

## Test plan
- Push idx 5 (taken=1), then resolve taken=1 → next cycle upd_en=1, upd_idx=5, upd_taken=1, flush=0.
- Push idx 3 (taken=0), resolve taken=1 with res_pc_next=0x400 → next cycle flush=1, redirect_pc=0x400, upd_taken=1; flush=0 the cycle after.
- Push 4 entries with no resolve → pred_ready=0; a 5th pred_valid is not stored; after one resolve, pred_ready=1.
- 3 entries queued, head mispredicts, and pred_valid is asserted in the same cycle → count=0 afterwards and a later res_valid produces no upd_en.
- res_valid with an empty queue → no upd_en, no flush. Assert rst_n low mid-queue → all outputs reset immediately, pred_ready=1.
- With BRU_STATS_EN: 10 resolves including 3 mispredicts → stat_branches=10, stat_mispred=3.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and default constants for the branch resolve unit and its queue.
package bru_pkg;

  localparam int BRU_DEPTH_DEF = 4;
  localparam int BRU_IDX_W_DEF = 6;
  localparam int BRU_PC_W_DEF  = 32;
  // Upper bound on the predictor index width; unused high bits stay zero.
  localparam int BRU_IDX_W_MAX = 32;

  typedef struct packed {
    logic [BRU_IDX_W_MAX-1:0] idx;
    logic                     taken;
  } bru_entry_t;

  typedef enum logic {
    BRU_NORMAL,
    BRU_FLUSH
  } bru_state_e;

endpackage

// File: rtl/bru_queue.sv
// In-order circular buffer of issued predictions with push, pop and clear.
module bru_queue
  import bru_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  bru_entry_t       push_entry,
  input  logic             pop,
  input  logic             clear,
  output bru_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  bru_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + PTR_W'(1);
      if (clear) begin
        // Everything still queued is discarded, including a same-cycle push.
        rptr_reg  <= push_ok ? wptr_reg + PTR_W'(1) : wptr_reg;
        count_reg <= '0;
      end else begin
        if (pop_ok) rptr_reg <= rptr_reg + PTR_W'(1);
        unique case ({push_ok, pop_ok})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches fetch-time predictions against execute outcomes, drives predictor updates
// and one-cycle mispredict flushes. Define BRU_STATS_EN to add resolve/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH_DEF,
  parameter int IDX_W = BRU_IDX_W_DEF,
  parameter int PC_W  = BRU_PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_pc_next,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  bru_entry_t       head;
  bru_entry_t       push_entry;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             resolve;
  logic             mispredict;
  logic             push;
  logic             unused_q;
  bru_state_e       state_reg;
  bru_state_e       state_next;

  assign pred_ready = (count != CNT_W'(DEPTH));
  assign resolve    = res_valid && !empty;
  assign mispredict = resolve && (res_taken != head.taken);
  // Fetch is on the wrong path during a flush or when this cycle mispredicts.
  assign push       = pred_valid && pred_ready && !flush && !mispredict;
  assign unused_q   = ^{full, head.idx};

  always_comb begin
    push_entry              = '0;
    push_entry.idx[IDX_W-1:0] = pred_idx;
    push_entry.taken        = pred_taken;
  end

  bru_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (resolve),
    .clear      (mispredict),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= BRU_NORMAL;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = BRU_NORMAL;
    flush      = (state_reg == BRU_FLUSH);
    if (mispredict) state_next = BRU_FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_en      <= 1'b0;
      upd_idx     <= '0;
      upd_taken   <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_en <= resolve;
      if (resolve) begin
        upd_idx   <= head.idx[IDX_W-1:0];
        upd_taken <= res_taken;
      end
      if (mispredict) redirect_pc <= res_pc_next;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (resolve)    stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit (stats checked when BRU_STATS_EN is defined).
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int IDX_W = 6;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pred_valid = 1'b0;
  logic [IDX_W-1:0] pred_idx = '0;
  logic             pred_taken = 1'b0;
  logic             pred_ready;
  logic             res_valid = 1'b0;
  logic             res_taken = 1'b0;
  logic [PC_W-1:0]  res_pc_next = '0;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispred;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pred_valid  (pred_valid),
    .pred_idx    (pred_idx),
    .pred_taken  (pred_taken),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_pc_next (res_pc_next),
    .upd_en      (upd_en),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .flush       (flush),
    .redirect_pc (redirect_pc)
`ifdef BRU_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  typedef struct {
    logic             pv;
    logic [IDX_W-1:0] pidx;
    logic             pt;
    logic             rv;
    logic             rt;
    logic [PC_W-1:0]  rpc;
    logic             e_ready;
    logic             e_upd;
    logic [IDX_W-1:0] e_idx;
    logic             e_ut;
    logic             e_flush;
    logic [PC_W-1:0]  e_rpc;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic pv, int pidx, logic pt, logic rv, logic rt, int rpc,
                              logic e_ready, logic e_upd, int e_idx, logic e_ut,
                              logic e_flush, int e_rpc);
    vec_t v;
    v.pv = pv; v.pidx = IDX_W'(pidx); v.pt = pt;
    v.rv = rv; v.rt = rt; v.rpc = PC_W'(rpc);
    v.e_ready = e_ready; v.e_upd = e_upd; v.e_idx = IDX_W'(e_idx); v.e_ut = e_ut;
    v.e_flush = e_flush; v.e_rpc = PC_W'(e_rpc);
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_idx = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_pc_next = '0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_pred_ready"}, 32'(pred_ready), 32'd1);
    check({tag, "_upd_en"}, 32'(upd_en), 32'd0);
    check({tag, "_upd_idx"}, 32'(upd_idx), 32'd0);
    check({tag, "_upd_taken"}, 32'(upd_taken), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    //          pv idx pt rv rt rpc       ready upd idx ut flush rpc
    vecs[0]  = mk(1, 5,  1, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[1]  = mk(0, 0,  0, 1, 1, 0,       1, 1, 5,  1, 0, 0);
    vecs[2]  = mk(1, 3,  0, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[3]  = mk(0, 0,  0, 1, 1, 'h400,   1, 1, 3,  1, 1, 'h400);
    vecs[4]  = mk(0, 0,  0, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[5]  = mk(1, 1,  1, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[6]  = mk(1, 2,  0, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[7]  = mk(1, 3,  1, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[8]  = mk(1, 4,  0, 0, 0, 0,       0, 0, 0,  0, 0, 0);
    vecs[9]  = mk(1, 9,  1, 0, 0, 0,       0, 0, 0,  0, 0, 0);
    vecs[10] = mk(1, 10, 1, 1, 1, 0,       1, 1, 1,  1, 0, 0);
    vecs[11] = mk(0, 0,  0, 1, 0, 0,       1, 1, 2,  0, 0, 0);
    vecs[12] = mk(1, 6,  1, 1, 1, 0,       1, 1, 3,  1, 0, 0);
    vecs[13] = mk(1, 7,  0, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[14] = mk(1, 8,  1, 1, 1, 'h1234,  1, 1, 4,  1, 1, 'h1234);
    vecs[15] = mk(1, 11, 1, 1, 1, 0,       1, 0, 0,  0, 0, 0);
    vecs[16] = mk(0, 0,  0, 1, 1, 0,       1, 0, 0,  0, 0, 0);
    vecs[17] = mk(1, 12, 1, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[18] = mk(0, 0,  0, 1, 0, 'h80,    1, 1, 12, 0, 1, 'h80);
    vecs[19] = mk(1, 13, 0, 0, 0, 0,       1, 0, 0,  0, 0, 0);
    vecs[20] = mk(0, 0,  0, 1, 1, 0,       1, 0, 0,  0, 0, 0);

    idle_inputs();
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) begin
      pred_valid = vecs[i].pv; pred_idx = vecs[i].pidx; pred_taken = vecs[i].pt;
      res_valid = vecs[i].rv; res_taken = vecs[i].rt; res_pc_next = vecs[i].rpc;
      step();
      $display("vec %0d: ready=%0b upd_en=%0b upd_idx=%0d upd_taken=%0b flush=%0b redirect_pc=0x%0h",
               i, pred_ready, upd_en, upd_idx, upd_taken, flush, redirect_pc);
      check($sformatf("v%0d_pred_ready", i), 32'(pred_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_upd_en", i), 32'(upd_en), 32'(vecs[i].e_upd));
      check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      if (vecs[i].e_upd) begin
        check($sformatf("v%0d_upd_idx", i), 32'(upd_idx), 32'(vecs[i].e_idx));
        check($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
      end
      if (vecs[i].e_flush)
        check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
    end
    idle_inputs();

    // Async reset while an update and a flush are being presented.
    pred_valid = 1'b1; pred_idx = 6'd20; pred_taken = 1'b1;
    step();
    pred_idx = 6'd21; pred_taken = 1'b0;
    step();
    idle_inputs();
    res_valid = 1'b1; res_taken = 1'b0; res_pc_next = 32'h55;
    step();
    idle_inputs();
    $display("pre-reset: upd_en=%0b flush=%0b redirect_pc=0x%0h", upd_en, flush, redirect_pc);
    check("arst_pre_flush", 32'(flush), 32'd1);
    check("arst_pre_upd_en", 32'(upd_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid-cycle reset: ready=%0b upd_en=%0b flush=%0b", pred_ready, upd_en, flush);
    check_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    res_valid = 1'b1; res_taken = 1'b1;
    step();
    idle_inputs();
    $display("post-reset resolve: upd_en=%0b flush=%0b", upd_en, flush);
    check("arst_post_upd_en", 32'(upd_en), 32'd0);
    check("arst_post_flush", 32'(flush), 32'd0);

`ifdef BRU_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("stat_reset_branches", stat_branches, 32'd0);
    check("stat_reset_mispred", stat_mispred, 32'd0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      pred_valid = 1'b1; pred_idx = IDX_W'(i); pred_taken = 1'b1;
      step();
      idle_inputs();
      res_valid = 1'b1;
      res_taken = (i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1;
      step();
      idle_inputs();
      step();
    end
    $display("stats: branches=%0d mispred=%0d", stat_branches, stat_mispred);
    check("stat_branches", stat_branches, 32'd10);
    check("stat_mispred", stat_mispred, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
